counter_seq_checker: RTL and testbench
======================================

// Module: counter_seq_checker
// PURPOSE
//  Receive-side monitor for the free-running enabled 16-bit user-design counter.
//  Samples the counter bus on each qualified cycle and checks that every sample is previous+1
//  mod 2^WIDTH, or 0 when a counter reset is allowed.
//  Locks after LOCK_COUNT consecutive good samples and reports mismatches.
//  Counts errors and drops lock after ERR_LIMIT consecutive errors.
//  Sits on the fabric output pins of the counter design as an on-fabric loopback self-check.
// PARAMETERS
//  WIDTH      16  width of observed counter bus
//  LOCK_COUNT 4   consecutive in-sequence samples needed to enter LOCKED (>=2)
//  ERR_LIMIT  3   consecutive mismatches in LOCKED that force return to HUNT (>=1)
//  ERRCNT_W   16  width of saturating error counter
// PORTS
//  clk          in   1         fabric global clock
//  reset        in   1         synchronous, active-high; clock clk
//  sample_valid in   1         count_in is a new counter value this cycle (counter enable)
//  count_in     in   WIDTH     observed counter value
//  zero_ok      in   1         a sample of 0 is legal resync (counter reset asserted)
//  clear_errs   in   1         synchronous clear of err_count
//  locked       out  1         1 while in LOCKED state
//  err_pulse    out  1         one-cycle strobe per mismatch detected in LOCKED
//  err_count    out  ERRCNT_W  mismatches since reset/clear, saturating at all-ones
//  last_sample  out  WIDTH     most recent accepted count_in
// BEHAVIOUR
//  - All outputs registered. reset: state=HUNT, have_ref=0, expected=0, good_run=0,
//    bad_run=0; locked=0, err_pulse=0, err_count=0, last_sample=0.
//  - sample_valid=0: all state holds, err_pulse=0 next cycle.
//  - Accepted sample: last_sample<=count_in. expected<=count_in+1 (mod 2^WIDTH) on every
//    accepted sample, so the checker always follows the stream.
//  - match := have_ref && (count_in==expected || (zero_ok && count_in==0)).
//  - Wrap: expected 0 after FFFF; sample 0x0000 following 0xFFFF is a match regardless of zero_ok.
//  - HUNT state:
//    - First sample sets have_ref=1, good_run=1.
//    - On match, good_run++. When good_run reaches LOCK_COUNT: go to LOCKED, locked=1, bad_run=0.
//    - On mismatch, good_run<=1. No err_pulse and no err_count change in HUNT.
//  - LOCKED state:
//    - On match, bad_run<=0.
//    - On mismatch: err_pulse=1 for exactly the cycle after the sampling edge, err_count++
//      (saturating), bad_run++.
//    - When bad_run reaches ERR_LIMIT: go to HUNT, locked=0 the same edge, good_run<=1.
//  - clear_errs in the same cycle as a counted mismatch gives err_count=1 (increment wins over clear).
//  - reset mid-stream overrides everything, including a concurrent sample or clear.
//  - No pipeline stall; one sample accepted per cycle back-to-back; latency 1 cycle to all outputs.
// STRUCTURE
//  - counter_seq_checker_defs.vh: state encodings ST_HUNT=1'b0, ST_LOCKED=1'b1;
//    default parameter values.
//  - One sub-module sat_counter #(W): sync clear, increment, increment-beats-clear,
//    saturate at all-ones. Instantiated for err_count; good_run/bad_run are local small regs.
//  - Single 2-state FSM plus compare datapath in top; no other hierarchy.
// TESTING
//  1. reset, then samples 0,1,2,3 -> locked=1 after 4th sample edge; err_count=0;
//     last_sample=3.
//  2. Locked; samples FFFE,FFFF,0000,0001 (zero_ok=0) -> no err_pulse; locked stays 1.
//  3. Locked at 0x0010; sample 0x0020 -> one err_pulse cycle, err_count=1. Then 0x0021 is a
//     match, so bad_run clears and locked stays 1.
//  4. Locked; three unrelated samples 0x5,0x9,0x100 -> err_count=3, locked=0 after 3rd.
//     Then 0x101,0x102,0x103 -> relocks on 0x103.
//  5. Locked at 0x40; zero_ok=1 with sample 0 -> match, no error.
//     Same with zero_ok=0 -> err_pulse, err_count+1.
//  6. err_count forced to FFFF (ERRCNT_W=16) + mismatch -> stays FFFF.
//     clear_errs+mismatch same cycle -> 1. reset mid-lock -> all outputs 0, HUNT.

Source files
------------

// File: rtl/counter_seq_checker_pkg.sv
// counter_seq_checker_pkg: FSM state encoding and default parameter values for the counter sequence checker
package counter_seq_checker_pkg;
    typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;
    localparam int DEF_WIDTH      = 16;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_ERR_LIMIT  = 3;
    localparam int DEF_ERRCNT_W   = 16;
endpackage

// File: rtl/counter_seq_checker_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear where a same-cycle increment beats the clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);
    // increment restarts from zero when clear coincides, and sticks at all-ones
    always_ff @(posedge clk)
        if (reset) q <= '0;
        else if (inc) q <= clear ? W'(1) : (&q ? q : q + W'(1));
        else if (clear) q <= '0;
endmodule

// File: rtl/counter_seq_checker.sv
// counter_seq_checker: loopback monitor checking that an observed counter increments by one per enabled cycle
module counter_seq_checker
    import counter_seq_checker_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int ERR_LIMIT  = DEF_ERR_LIMIT,
    parameter int ERRCNT_W   = DEF_ERRCNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [WIDTH-1:0]    count_in,
    input  logic                zero_ok,
    input  logic                clear_errs,
    output logic                locked,
    output logic                err_pulse,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [WIDTH-1:0]    last_sample
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(ERR_LIMIT + 1);
    state_t           state;
    logic             have_ref;
    logic [WIDTH-1:0] expected;
    logic [GW-1:0]    good_run;
    logic [BW-1:0]    bad_run;
    logic             match;
    logic             count_err;
    // a zero sample is a legal resync only while the counter reset is asserted; wrap falls out of expected
    always_comb begin
        match     = have_ref && (count_in == expected || (zero_ok && count_in == '0));
        count_err = sample_valid && state == ST_LOCKED && !match;
    end
    // lock acquisition, error run tracking and sample capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_HUNT;
            have_ref    <= 1'b0;
            expected    <= '0;
            good_run    <= '0;
            bad_run     <= '0;
            err_pulse   <= 1'b0;
            last_sample <= '0;
        end else begin
            err_pulse <= count_err;
            if (sample_valid) begin
                last_sample <= count_in;
                expected    <= count_in + WIDTH'(1);
                have_ref    <= 1'b1;
                if (state == ST_HUNT) begin
                    good_run <= match ? good_run + GW'(1) : GW'(1);
                    if (match && good_run == GW'(LOCK_COUNT - 1)) begin
                        state   <= ST_LOCKED;
                        bad_run <= '0;
                    end
                end else if (match) begin
                    bad_run <= '0;
                end else if (bad_run == BW'(ERR_LIMIT - 1)) begin
                    state    <= ST_HUNT;
                    good_run <= GW'(1);
                    bad_run  <= '0;
                end else begin
                    bad_run <= bad_run + BW'(1);
                end
            end
        end
    end
    assign locked = (state == ST_LOCKED);
    sat_counter #(.W(ERRCNT_W)) u_err (
        .clk   (clk),
        .reset (reset),
        .clear (clear_errs),
        .inc   (count_err),
        .q     (err_count)
    );
endmodule

// File: tb/tb_counter_seq_checker.sv
// tb_counter_seq_checker: directed scoreboard bench for counter_seq_checker
module tb_counter_seq_checker;
    typedef struct packed {
        logic        lk;
        logic        pulse;
        logic [15:0] err;
        logic [15:0] last;
        logic [2:0]  errs;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] count_in = '0;
    logic        zero_ok = 1'b0;
    logic        clear_errs = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count, last_sample;
    logic        s_locked, s_pulse;
    logic [2:0]  s_err;
    logic [15:0] s_last;
    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    string       cur = "init";
    logic        m_locked = 1'b0, m_have = 1'b0;
    logic [15:0] m_exp = '0, m_err = '0, m_last = '0;
    logic [2:0]  m_errs = '0;
    int          m_good = 0, m_bad = 0;

    counter_seq_checker dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .count_in(count_in),
        .zero_ok(zero_ok), .clear_errs(clear_errs), .locked(locked),
        .err_pulse(err_pulse), .err_count(err_count), .last_sample(last_sample)
    );

    counter_seq_checker #(.ERRCNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .count_in(count_in),
        .zero_ok(zero_ok), .clear_errs(clear_errs), .locked(s_locked),
        .err_pulse(s_pulse), .err_count(s_err), .last_sample(s_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, got, want);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic z = 1'b0,
                        input logic c = 1'b0, input logic r = 1'b0);
        logic mt, cnt;
        exp_t e, g;
        if (r) begin
            m_locked = 0; m_have = 0; m_exp = 0; m_err = 0; m_last = 0; m_errs = 0;
            m_good = 0; m_bad = 0; cnt = 0;
        end else begin
            mt  = m_have && (d == m_exp || (z && d == 16'h0));
            cnt = v && m_locked && !mt;
            if (cnt) begin
                m_err  = c ? 16'd1 : (m_err == 16'hFFFF ? m_err : m_err + 16'd1);
                m_errs = c ? 3'd1 : (m_errs == 3'd7 ? m_errs : m_errs + 3'd1);
            end else if (c) begin
                m_err = 0; m_errs = 0;
            end
            if (v) begin
                m_last = d; m_exp = d + 16'd1; m_have = 1;
                if (!m_locked) begin
                    m_good = mt ? m_good + 1 : 1;
                    if (m_good == 4) begin m_locked = 1; m_bad = 0; end
                end else if (mt) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad == 3) begin m_locked = 0; m_good = 1; m_bad = 0; end
                end
            end
        end
        e = '{lk: m_locked, pulse: cnt, err: m_err, last: m_last, errs: m_errs};
        sb.push_back(e);
        sample_valid = v; count_in = d; zero_ok = z; clear_errs = c; reset = r;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("locked", 32'(locked), 32'(g.lk));
        chk("err_pulse", 32'(err_pulse), 32'(g.pulse));
        chk("err_count", 32'(err_count), 32'(g.err));
        chk("last_sample", 32'(last_sample), 32'(g.last));
        chk("narrow_err_count", 32'(s_err), 32'(g.errs));
        chk("narrow_locked", 32'(s_locked), 32'(g.lk));
        chk("narrow_last", 32'(s_last), 32'(g.last));
        chk("narrow_pulse", 32'(s_pulse), 32'(g.pulse));
        sample_valid = 0; clear_errs = 0; reset = 0; zero_ok = 0;
    endtask

    initial begin
        cur = "reset";
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_locked", 32'(locked), 32'h0);
        chk("reset_err", 32'(err_count), 32'h0);
        cur = "t1_lock";
        for (int i = 0; i < 4; i++) begin
            chk("pre_lock", 32'(locked), 32'h0);
            step(1'b1, 16'(i));
        end
        chk("t1_locked", 32'(locked), 32'h1);
        chk("t1_err", 32'(err_count), 32'h0);
        chk("t1_last", 32'(last_sample), 32'h3);
        cur = "t2_wrap";
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 16'hFFFA + 16'(i));
        chk("t2_locked", 32'(locked), 32'h1);
        chk("t2_err", 32'(err_count), 32'h0);
        cur = "t3_single_err";
        for (int i = 2; i <= 16; i++) step(1'b1, 16'(i));
        step(1'b0, 16'hBEEF);
        step(1'b0, 16'h1234);
        step(1'b1, 16'h0020);
        chk("t3_pulse", 32'(err_pulse), 32'h1);
        chk("t3_err", 32'(err_count), 32'h1);
        step(1'b1, 16'h0021);
        chk("t3_pulse_gone", 32'(err_pulse), 32'h0);
        step(1'b1, 16'h0022);
        chk("t3_still_locked", 32'(locked), 32'h1);
        cur = "t4_drop";
        step(1'b1, 16'h0005);
        step(1'b1, 16'h0009);
        chk("t4_locked_mid", 32'(locked), 32'h1);
        step(1'b1, 16'h0100);
        chk("t4_err", 32'(err_count), 32'h4);
        chk("t4_unlocked", 32'(locked), 32'h0);
        step(1'b1, 16'h0101);
        step(1'b1, 16'h0102);
        chk("t4_not_yet", 32'(locked), 32'h0);
        step(1'b1, 16'h0103);
        chk("t4_relock", 32'(locked), 32'h1);
        cur = "t5_zero_ok";
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h003D + 16'(i));
        step(1'b1, 16'h0000, 1'b1);
        chk("t5_zero_ok_pulse", 32'(err_pulse), 32'h0);
        chk("t5_zero_ok_err", 32'(err_count), 32'h0);
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0000, 1'b0);
        chk("t5_zero_bad_pulse", 32'(err_pulse), 32'h1);
        chk("t5_zero_bad_err", 32'(err_count), 32'h1);
        cur = "t6_sat";
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 16'h0500 + 16'(i * 16));
            step(1'b1, 16'h0501 + 16'(i * 16));
        end
        chk("t6_narrow_sat", 32'(s_err), 32'h7);
        chk("t6_wide", 32'(err_count), 32'd10);
        step(1'b1, 16'h0700, 1'b0, 1'b1);
        chk("t6_clear_inc", 32'(err_count), 32'h1);
        step(1'b1, 16'h0701, 1'b0, 1'b1);
        chk("t6_clear", 32'(err_count), 32'h0);
        step(1'b1, 16'h0702);
        step(1'b1, 16'h0900, 1'b0, 1'b1, 1'b1);
        chk("t6_reset_locked", 32'(locked), 32'h0);
        chk("t6_reset_last", 32'(last_sample), 32'h0);
        chk("t6_reset_err", 32'(err_count), 32'h0);
        step(1'b1, 16'h0777);
        chk("t6_first_after_reset", 32'(err_pulse), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
